// File: rtl/dma_loop_pkt_fifo.sv
// Loopback packet FIFO between an MM2S and an S2MM AXI-Stream port, with a 2-cycle
// cut-through path and an optional store-and-forward gate that falls back to cut-through.
module dma_loop_pkt_fifo #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DEPTH_W        = 10,
  parameter int AFULL_MARGIN   = 256,
  parameter int PKT_MODE       = 0,
  localparam int BE_WIDTH      = AXI_DATA_WIDTH / 8
) (
  input  logic                      axi_clk,
  input  logic                      axi_rst,
  input  logic [AXI_DATA_WIDTH-1:0] m_axis_mm2s_tdata,
  input  logic [BE_WIDTH-1:0]       m_axis_mm2s_tkeep,
  input  logic                      m_axis_mm2s_tvalid,
  input  logic                      m_axis_mm2s_tlast,
  output logic                      m_axis_mm2s_tready,
  output logic [AXI_DATA_WIDTH-1:0] s_axis_s2mm_tdata,
  output logic [BE_WIDTH-1:0]       s_axis_s2mm_tkeep,
  output logic                      s_axis_s2mm_tlast,
  output logic                      s_axis_s2mm_tvalid,
  input  logic                      s_axis_s2mm_tready,
  output logic [DEPTH_W:0]          usedw,
  output logic [DEPTH_W:0]          pkt_count,
  output logic                      oversize,
  output logic                      fsm_state_o
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam int WW    = AXI_DATA_WIDTH + BE_WIDTH + 1;
  localparam logic [DEPTH_W:0] THRESH = (DEPTH_W + 1)'(DEPTH - AFULL_MARGIN);
  localparam logic [DEPTH_W:0] ONE    = (DEPTH_W + 1)'(1);

  typedef enum logic {
    GATED    = 1'b0,
    CUT_THRU = 1'b1
  } state_t;

  // Handshake: a beat moves on a port exactly at a rising edge where valid && ready;
  // the egress valid/data/keep/last come straight from registers and never change
  // while valid is high and ready is low.

  logic [WW-1:0]    mem_q [DEPTH];
  logic [DEPTH_W:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0] rd_ptr_q, rd_ptr_d;
  logic             stg_vld_q, stg_vld_d;
  logic [WW-1:0]    stg_word_q;
  logic             out_vld_q, out_vld_d;
  logic [WW-1:0]    out_word_q, out_word_d;
  logic [DEPTH_W:0] usedw_q, usedw_d;
  logic [DEPTH_W:0] pkt_q, pkt_d;
  logic [DEPTH_W:0] mem_pkts_q, mem_pkts_d;
  state_t           state_q, state_d;
  logic             ovs_q, ovs_d;
  logic             ct_done_q, ct_done_d;
  logic             rdy_en_q;

  logic          in_ready;
  logic          wr_en;
  logic          retire;
  logic          stg_adv;
  logic          rd_gate;
  logic          rd_en;
  logic [WW-1:0] rd_word;
  logic          rd_last;
  logic          ret_last;
  logic          mem_empty;

  assign in_ready  = rdy_en_q && (usedw_q < THRESH);
  assign wr_en     = m_axis_mm2s_tvalid && in_ready;
  assign retire    = out_vld_q && s_axis_s2mm_tready;
  assign stg_adv   = stg_vld_q && (!out_vld_q || s_axis_s2mm_tready);
  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign rd_word   = mem_q[rd_ptr_q[DEPTH_W-1:0]];
  assign rd_last   = rd_word[WW-1];
  assign ret_last  = out_word_q[WW-1];
  assign rd_en     = !mem_empty && rd_gate && (!stg_vld_q || stg_adv);

  // Store-and-forward only releases beats of packets whose tlast is already in
  // storage; in cut-through, reads stop after the oversized packet's tlast.
  always_comb begin
    rd_gate = 1'b1;
    if (PKT_MODE != 0) begin
      rd_gate = (mem_pkts_q != '0) || ((state_q == CUT_THRU) && !ct_done_q);
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    stg_vld_d  = stg_vld_q;
    out_vld_d  = out_vld_q;
    out_word_d = out_word_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (rd_en) begin
      rd_ptr_d  = rd_ptr_q + ONE;
      stg_vld_d = 1'b1;
    end else if (stg_adv) begin
      stg_vld_d = 1'b0;
    end
    if (stg_adv) begin
      out_vld_d  = 1'b1;
      out_word_d = stg_word_q;
    end else if (retire) begin
      out_vld_d = 1'b0;
    end
  end

  always_comb begin
    usedw_d    = usedw_q;
    pkt_d      = pkt_q;
    mem_pkts_d = mem_pkts_q;
    if (wr_en && !retire) begin
      usedw_d = usedw_q + ONE;
    end else if (!wr_en && retire) begin
      usedw_d = usedw_q - ONE;
    end
    if ((wr_en && m_axis_mm2s_tlast) && !(retire && ret_last)) begin
      pkt_d = pkt_q + ONE;
    end else if (!(wr_en && m_axis_mm2s_tlast) && (retire && ret_last)) begin
      pkt_d = pkt_q - ONE;
    end
    if ((wr_en && m_axis_mm2s_tlast) && !(rd_en && rd_last)) begin
      mem_pkts_d = mem_pkts_q + ONE;
    end else if (!(wr_en && m_axis_mm2s_tlast) && (rd_en && rd_last)) begin
      mem_pkts_d = mem_pkts_q - ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    ovs_d     = ovs_q;
    ct_done_d = ct_done_q;
    if (PKT_MODE != 0) begin
      case (state_q)
        GATED: begin
          // Buffer near full with no complete packet: it can never complete in place.
          if ((usedw_q >= THRESH) && (pkt_q == '0)) begin
            state_d   = CUT_THRU;
            ovs_d     = 1'b1;
            ct_done_d = 1'b0;
          end
        end
        CUT_THRU: begin
          if (rd_en && rd_last) begin
            ct_done_d = 1'b1;
          end
          if (retire && ret_last) begin
            state_d   = GATED;
            ct_done_d = 1'b0;
          end
        end
        default: begin
          state_d = GATED;
        end
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[DEPTH_W-1:0]] <= {m_axis_mm2s_tlast, m_axis_mm2s_tkeep, m_axis_mm2s_tdata};
    end
    if (rd_en) begin
      stg_word_q <= rd_word;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stg_vld_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_word_q <= '0;
      usedw_q    <= '0;
      pkt_q      <= '0;
      mem_pkts_q <= '0;
      state_q    <= GATED;
      ovs_q      <= 1'b0;
      ct_done_q  <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stg_vld_q  <= stg_vld_d;
      out_vld_q  <= out_vld_d;
      out_word_q <= out_word_d;
      usedw_q    <= usedw_d;
      pkt_q      <= pkt_d;
      mem_pkts_q <= mem_pkts_d;
      state_q    <= state_d;
      ovs_q      <= ovs_d;
      ct_done_q  <= ct_done_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign m_axis_mm2s_tready = in_ready;
  assign s_axis_s2mm_tvalid = out_vld_q;
  assign s_axis_s2mm_tdata  = out_word_q[AXI_DATA_WIDTH-1:0];
  assign s_axis_s2mm_tkeep  = out_word_q[AXI_DATA_WIDTH +: BE_WIDTH];
  assign s_axis_s2mm_tlast  = out_word_q[WW-1];
  assign usedw              = usedw_q;
  assign pkt_count          = pkt_q;
  assign oversize           = ovs_q;
  assign fsm_state_o        = (state_q == CUT_THRU);

endmodule

// File: tb/tb_dma_loop_pkt_fifo.sv
// Bench for dma_loop_pkt_fifo: instance 0 cut-through, instance 1 store-and-forward,
// driven by directed tasks and checked by a per-instance expected-beat queue.
module tb_dma_loop_pkt_fifo;
  localparam int W  = 64;
  localparam int BE = 8;
  localparam int DW = 10;
  localparam int WW = W + BE + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0][W-1:0]  in_data;
  logic [1:0][BE-1:0] in_keep;
  logic [1:0]         in_valid;
  logic [1:0]         in_last;
  wire  [1:0]         in_ready;
  wire  [1:0][W-1:0]  out_data;
  wire  [1:0][BE-1:0] out_keep;
  wire  [1:0]         out_last;
  wire  [1:0]         out_valid;
  wire  [1:0]         out_ready;
  wire  [1:0][DW:0]   usedw;
  wire  [1:0][DW:0]   pkt_cnt;
  wire  [1:0]         ovs;
  wire  [1:0]         st;

  logic [1:0] dir_rdy;
  logic [1:0] rnd_rdy;
  logic [1:0] rand_rdy;
  assign out_ready[0] = rand_rdy[0] ? rnd_rdy[0] : dir_rdy[0];
  assign out_ready[1] = rand_rdy[1] ? rnd_rdy[1] : dir_rdy[1];

  logic [WW-1:0] exp_q0[$];
  logic [WW-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;
  int ret_cnt[2];
  int valid_cnt[2];

  dma_loop_pkt_fifo #(.AXI_DATA_WIDTH(W), .DEPTH_W(DW), .AFULL_MARGIN(256), .PKT_MODE(0)) u_ct (
    .axi_clk(clk), .axi_rst(rst),
    .m_axis_mm2s_tdata(in_data[0]), .m_axis_mm2s_tkeep(in_keep[0]),
    .m_axis_mm2s_tvalid(in_valid[0]), .m_axis_mm2s_tlast(in_last[0]),
    .m_axis_mm2s_tready(in_ready[0]),
    .s_axis_s2mm_tdata(out_data[0]), .s_axis_s2mm_tkeep(out_keep[0]),
    .s_axis_s2mm_tlast(out_last[0]), .s_axis_s2mm_tvalid(out_valid[0]),
    .s_axis_s2mm_tready(out_ready[0]),
    .usedw(usedw[0]), .pkt_count(pkt_cnt[0]), .oversize(ovs[0]), .fsm_state_o(st[0])
  );

  dma_loop_pkt_fifo #(.AXI_DATA_WIDTH(W), .DEPTH_W(DW), .AFULL_MARGIN(256), .PKT_MODE(1)) u_sf (
    .axi_clk(clk), .axi_rst(rst),
    .m_axis_mm2s_tdata(in_data[1]), .m_axis_mm2s_tkeep(in_keep[1]),
    .m_axis_mm2s_tvalid(in_valid[1]), .m_axis_mm2s_tlast(in_last[1]),
    .m_axis_mm2s_tready(in_ready[1]),
    .s_axis_s2mm_tdata(out_data[1]), .s_axis_s2mm_tkeep(out_keep[1]),
    .s_axis_s2mm_tlast(out_last[1]), .s_axis_s2mm_tvalid(out_valid[1]),
    .s_axis_s2mm_tready(out_ready[1]),
    .usedw(usedw[1]), .pkt_count(pkt_cnt[1]), .oversize(ovs[1]), .fsm_state_o(st[1])
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=bound_expired required=event_within_bound", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input int k, input logic [W-1:0] d, input logic [BE-1:0] kp, input logic l);
    int n;
    n = 0;
    in_data[k]  = d;
    in_keep[k]  = kp;
    in_last[k]  = l;
    in_valid[k] = 1'b1;
    @(negedge clk);
    while (!in_ready[k] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      fail_to("send_ready");
      in_valid[k] = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    if (k == 0) exp_q0.push_back({l, kp, d});
    else        exp_q1.push_back({l, kp, d});
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k, input int bound);
    int n;
    n = 0;
    while (n < bound && (usedw[k] != '0 || ((k == 0) ? exp_q0.size() : exp_q1.size()) != 0)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= bound) fail_to("drain");
  endtask

  task automatic stream(input int k, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      send_beat(k, {$urandom, $urandom}, 8'($urandom_range(1, 255)),
                (i == nbeats - 1) || ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_tvalid"}, out_valid[k], 0);
      chk({tag, "_tready"}, in_ready[k], 0);
      chk({tag, "_usedw"}, usedw[k], 0);
      chk({tag, "_pkt"}, pkt_cnt[k], 0);
      chk({tag, "_oversize"}, ovs[k], 0);
      chk({tag, "_fsm"}, st[k], 0);
      chk({tag, "_beat"}, {out_last[k], out_keep[k], out_data[k]}, 0);
    end
  endtask

  // ---------------- egress ready randomiser ----------------
  initial begin
    rnd_rdy = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = 2'($urandom_range(0, 3));
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [1:0]    stall_q = 2'b00;
  logic [WW-1:0] hold_q[2];
  logic [WW-1:0] mon_w;
  logic [WW-1:0] mon_e;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        stall_q[k] = 1'b0;
      end else begin
        mon_w = {out_last[k], out_keep[k], out_data[k]};
        if (stall_q[k]) begin
          chk("stall_tvalid", out_valid[k], 1);
          chk("stall_beat", mon_w, hold_q[k]);
        end
        if (out_valid[k]) valid_cnt[k]++;
        if (out_valid[k] && out_ready[k]) begin
          ret_cnt[k]++;
          if (k == 0 && exp_q0.size() > 0) begin
            mon_e = exp_q0.pop_front();
            chk("beat_ct", mon_w, mon_e);
          end else if (k == 1 && exp_q1.size() > 0) begin
            mon_e = exp_q1.pop_front();
            chk("beat_sf", mon_w, mon_e);
          end else begin
            errors++;
            checks++;
            $display("FAIL beat_unexpected inst=%0d actual=%0h required=none", k, mon_w);
          end
        end
        stall_q[k] = out_valid[k] && !out_ready[k];
        hold_q[k]  = mon_w;
      end
    end
  end

  // ---------------- directed sequence ----------------
  int r0;
  int v0;

  initial begin
    in_data  = '0;
    in_keep  = '0;
    in_valid = '0;
    in_last  = '0;
    dir_rdy  = 2'b00;
    rand_rdy = 2'b00;
    ret_cnt[0] = 0; ret_cnt[1] = 0;
    valid_cnt[0] = 0; valid_cnt[1] = 0;
    #1 rst = 1'b1;
    #2 reset_checks("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("tready_before_edge", in_ready, 2'b00);
    @(posedge clk);
    #1 chk("tready_after_edge", in_ready, 2'b11);

    // single beat, cut-through latency
    dir_rdy[0] = 1'b1;
    send_beat(0, 64'hA5, 8'hFF, 1'b1);
    chk("a_usedw_n", usedw[0], 1);
    chk("a_pkt_n", pkt_cnt[0], 1);
    chk("a_tvalid_n", out_valid[0], 0);
    @(posedge clk); #1 chk("a_tvalid_n1", out_valid[0], 0);
    @(posedge clk); #1 chk("a_tvalid_n2", out_valid[0], 1);
    chk("a_beat_n2", {out_last[0], out_keep[0], out_data[0]}, {1'b1, 8'hFF, 64'hA5});
    @(posedge clk); #1 chk("a_usedw_done", usedw[0], 0);
    chk("a_pkt_done", pkt_cnt[0], 0);
    chk("a_tvalid_done", out_valid[0], 0);

    // burst into stalled egress until threshold
    dir_rdy[0] = 1'b0;
    for (int i = 0; i < 767; i++)
      send_beat(0, 64'hB0B0_0000 + 64'(i), 8'(8'hFF << (i % 8)), (i % 16) == 15);
    chk("b_tready_767", in_ready[0], 1);
    send_beat(0, 64'hB0B0_0000 + 64'd767, 8'h80, 1'b1);
    chk("b_usedw_768", usedw[0], 768);
    chk("b_tready_768", in_ready[0], 0);
    chk("b_pkt_768", pkt_cnt[0], 48);
    repeat (5) @(posedge clk);
    #1 chk("b_tready_hold", in_ready[0], 0);
    chk("b_usedw_hold", usedw[0], 768);
    r0 = ret_cnt[0];
    dir_rdy[0] = 1'b1;
    repeat (768) @(posedge clk);
    #1 chk("b_drain_rate", ret_cnt[0] - r0, 768);
    chk("b_usedw_empty", usedw[0], 0);
    chk("b_tvalid_empty", out_valid[0], 0);
    chk("b_pkt_empty", pkt_cnt[0], 0);

    // store-and-forward: nothing leaves before tlast
    dir_rdy[1] = 1'b1;
    v0 = valid_cnt[1];
    for (int i = 0; i < 3; i++) send_beat(1, 64'hC0 + 64'(i), 8'h0F, 1'b0);
    repeat (10) @(posedge clk);
    #1 chk("c_no_tvalid", valid_cnt[1] - v0, 0);
    chk("c_usedw_3", usedw[1], 3);
    chk("c_pkt_0", pkt_cnt[1], 0);
    send_beat(1, 64'hC3, 8'h0F, 1'b1);
    chk("c_pkt_1", pkt_cnt[1], 1);
    chk("c_tvalid_n", out_valid[1], 0);
    @(posedge clk); #1 chk("c_tvalid_n1", out_valid[1], 0);
    @(posedge clk); #1 chk("c_tvalid_n2", out_valid[1], 1);
    chk("c_first_beat", {out_last[1], out_keep[1], out_data[1]}, {1'b0, 8'h0F, 64'hC0});
    repeat (4) @(posedge clk);
    #1 chk("c_pkt_done", pkt_cnt[1], 0);
    chk("c_usedw_done", usedw[1], 0);

    // oversize packet falls back to cut-through
    for (int i = 0; i < 768; i++) send_beat(1, 64'hD000 + 64'(i), 8'hFF, 1'b0);
    chk("d_usedw_768", usedw[1], 768);
    chk("d_tready_low", in_ready[1], 0);
    chk("d_oversize_pre", ovs[1], 0);
    chk("d_fsm_pre", st[1], 0);
    @(posedge clk);
    #1 chk("d_fsm_cut", st[1], 1);
    chk("d_oversize_set", ovs[1], 1);
    for (int i = 768; i < 800; i++) send_beat(1, 64'hD000 + 64'(i), 8'hFF, i == 799);
    wait_drain(1, 3000);
    chk("d_fsm_gated", st[1], 0);
    chk("d_oversize_sticky", ovs[1], 1);
    chk("d_pkt_done", pkt_cnt[1], 0);

    // reset mid-packet with 37 beats held
    dir_rdy[0] = 1'b0;
    for (int i = 0; i < 37; i++) send_beat(0, 64'hE000 + 64'(i), 8'h3C, 1'b0);
    chk("e_usedw_37", usedw[0], 37);
    #3 rst = 1'b1;
    #2 reset_checks("midrst");
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("e_tready_back", in_ready[0], 1);
    dir_rdy[0] = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(0, 64'hF000 + 64'(i), 8'h81, i == 4);
    wait_drain(0, 200);
    chk("e_pkt_done", pkt_cnt[0], 0);

    // throttled traffic on both instances, pointers wrap many times
    rand_rdy = 2'b11;
    fork
      stream(0, 10000);
      stream(1, 2000);
    join
    wait_drain(0, 20000);
    wait_drain(1, 20000);
    rand_rdy = 2'b00;
    chk("f_usedw0", usedw[0], 0);
    chk("f_usedw1", usedw[1], 0);
    chk("f_pkt0", pkt_cnt[0], 0);
    chk("f_pkt1", pkt_cnt[1], 0);
    chk("f_oversize1", ovs[1], 0);
    chk("f_oversize0", ovs[0], 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_loop_pkt_fifo.md
DMA_LOOP_PKT_FIFO -- requirements
Module: dma_loop_pkt_fifo

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 64: tdata width; SHALL be a multiple of 8; BE_WIDTH = AXI_DATA_WIDTH/8.
REQ-002 Parameter DEPTH_W, default 10: storage depth SHALL be 2**DEPTH_W beats (DEPTH).
REQ-003 Parameter AFULL_MARGIN, default 256: free-entry reserve; m_axis_mm2s_tready SHALL deassert when usedw >= DEPTH - AFULL_MARGIN.
REQ-004 Parameter PKT_MODE, default 0: 0 = cut-through, 1 = store-and-forward.
REQ-005 axi_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 axi_rst  in  1  reset, asynchronous, active-high.
REQ-007 m_axis_mm2s_tdata  in  AXI_DATA_WIDTH  ingress beat data.
REQ-008 m_axis_mm2s_tkeep  in  BE_WIDTH  ingress byte enables.
REQ-009 m_axis_mm2s_tvalid  in  1  ingress beat valid.
REQ-010 m_axis_mm2s_tlast  in  1  ingress end-of-packet.
REQ-011 m_axis_mm2s_tready  out  1  ingress ready.
REQ-012 s_axis_s2mm_tdata / tkeep / tlast  out  AXI_DATA_WIDTH / BE_WIDTH / 1  egress beat.
REQ-013 s_axis_s2mm_tvalid  out  1  egress valid; s_axis_s2mm_tready  in  1  egress ready.
REQ-014 usedw  out  DEPTH_W+1  beats held (storage plus output register).
REQ-015 pkt_count  out  DEPTH_W+1  complete packets (tlast written, not yet read out).
REQ-016 oversize  out  1  sticky: a packet exceeded buffer capacity in PKT_MODE=1.

Function
REQ-017 Beat SHALL be written when m_axis_mm2s_tvalid && m_axis_mm2s_tready; {tlast, tkeep, tdata} stored unaltered.
REQ-018 Egress SHALL use a registered output stage: tvalid/tdata/tkeep/tlast held stable while tvalid && !tready; beat retires on tvalid && tready.
REQ-019 Throughput: one beat per cycle sustained when ingress valid and egress ready continuously.
REQ-020 PKT_MODE=0: beat accepted at edge N into empty block SHALL present tvalid=1 after edge N+2 (2-cycle latency).
REQ-021 PKT_MODE=1: egress SHALL present beats only while pkt_count>0 or state CUT_THRU; first beat of a packet SHALL appear 2 edges after its tlast beat is accepted, when output was idle.
REQ-022 pkt_count SHALL +1 on write of a tlast beat, -1 on retire of a tlast beat; simultaneous events leave it unchanged.
REQ-023 usedw SHALL +1 per write, -1 per retire; simultaneous write and retire leave it unchanged; never exceeds DEPTH.
REQ-024 PKT_MODE=1 FSM states GATED (reset) and CUT_THRU: GATED->CUT_THRU when usedw >= DEPTH - AFULL_MARGIN and pkt_count==0; set oversize=1 on this transition; CUT_THRU->GATED on retire of a tlast beat.
REQ-025 In CUT_THRU, egress SHALL drain as in PKT_MODE=0; in PKT_MODE=0 the FSM SHALL stay GATED and oversize SHALL stay 0.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH without loss; full (usedw==DEPTH) SHALL never be overwritten; empty SHALL never produce tvalid.
REQ-027 Write of a beat and its retire in the same cycle are impossible (2-cycle latency); a write into a block with usedw one below threshold SHALL be accepted, tready low the next cycle.

Reset
REQ-028 While axi_rst=1 (asserted asynchronously, released synchronously): s_axis_s2mm_tvalid=0, m_axis_mm2s_tready=0, usedw=0, pkt_count=0, oversize=0, FSM=GATED, pointers=0; tdata/tkeep/tlast=0.
REQ-029 m_axis_mm2s_tready SHALL rise the first edge after reset release; reset mid-packet SHALL discard all held beats.

Verification
REQ-030 PKT_MODE=0, single beat tdata=0xA5, tkeep=0xFF, tlast=1, egress ready -> tvalid after exactly 2 edges, same values, usedw 1 then 0.
REQ-031 PKT_MODE=0, 1024-beat burst, egress tready=0 -> tready falls when usedw=768; release tready -> 768 beats in order, one per cycle.
REQ-032 PKT_MODE=1, 4-beat packet, tlast delayed 10 cycles -> no tvalid until 2 edges after tlast accepted; pkt_count 1 then 0.
REQ-033 PKT_MODE=1, 800-beat packet without tlast -> oversize=1 at usedw=768, FSM CUT_THRU, beats drain; after tlast retire FSM GATED, oversize stays 1.
REQ-034 Random tvalid/tready 50% throttling, 10k beats, pointer wrap -> data, tkeep, tlast match scoreboard; egress beats stable while stalled.
REQ-035 axi_rst asserted mid-packet with usedw=37 -> outputs reach REQ-028 values without clock edge; next packet passes intact.
